// File: rtl/load_store_mem_initiator.sv
// load_store_mem_initiator: single-outstanding load/store initiator for the core's data-memory port
// Ports:
//   clock, reset (async, active-low)
//   req_*   : pipeline request (valid/ready, write, size, unsigned, address, wdata)
//   resp_*  : one-cycle completion pulse with extended load data and error flag
//   busy    : request in flight
//   mem_*   : memory request strobes, byte enables, aligned address, lane-replicated data,
//             read data / echoed address / valid back from memory, mem_ready flow control
module load_store_mem_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic                    busy,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic [ADDRESS_BITS-1:0] mem_address_in,
  input  logic                    mem_valid,
  input  logic                    mem_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic cap_write, cap_write_nx, cap_unsigned, cap_unsigned_nx;
  logic [1:0] cap_size, cap_size_nx, cap_off, cap_off_nx;
  logic [BW-1:0] be_nx;
  logic [ADDRESS_BITS-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wd_nx, rd_nx, sh, ext;
  logic rv_nx, re_nx, bad, hit;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_address[0]) ||
               (req_size == 2'b10 && req_address[1:0] != 2'b00);
  assign hit = mem_valid && mem_address_in == mem_address;
  assign sh = mem_rdata >> {cap_off, 3'b000};
  assign ext = cap_size == 2'b00 ? {{24{!cap_unsigned && sh[7]}}, sh[7:0]} :
               cap_size == 2'b01 ? {{16{!cap_unsigned && sh[15]}}, sh[15:0]} : sh;
  assign cnt_inc = cnt == CW'(TIMEOUT_CYCLES) ? cnt : cnt + CW'(1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_write    <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_size     <= 2'b00;
      cap_off      <= 2'b00;
      mem_byte_en  <= '0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_error   <= 1'b0;
      resp_rdata   <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      cap_write    <= cap_write_nx;
      cap_unsigned <= cap_unsigned_nx;
      cap_size     <= cap_size_nx;
      cap_off      <= cap_off_nx;
      mem_byte_en  <= be_nx;
      mem_address  <= addr_nx;
      mem_wdata    <= wd_nx;
      resp_valid   <= rv_nx;
      resp_error   <= re_nx;
      resp_rdata   <= rd_nx;
    end
  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    cap_write_nx    = cap_write;
    cap_unsigned_nx = cap_unsigned;
    cap_size_nx     = cap_size;
    cap_off_nx      = cap_off;
    be_nx           = mem_byte_en;
    addr_nx         = mem_address;
    wd_nx           = mem_wdata;
    rv_nx           = 1'b0;
    re_nx           = 1'b0;
    rd_nx           = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    case (state)
      IDLE:
        if (req_valid) begin
          cap_write_nx    = req_write;
          cap_unsigned_nx = req_unsigned;
          cap_size_nx     = req_size;
          cap_off_nx      = req_address[1:0];
          if (bad) begin
            rv_nx = 1'b1;
            re_nx = 1'b1;
          end else begin
            state_nx = ISSUE;
            addr_nx  = {req_address[ADDRESS_BITS-1:2], 2'b00};
            be_nx    = req_size == 2'b00 ? 4'b0001 << req_address[1:0] :
                       req_size == 2'b01 ? 4'b0011 << req_address[1:0] : 4'b1111;
            wd_nx    = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                       req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
          end
        end
      ISSUE:
        if (mem_ready) begin
          mem_write = cap_write;
          mem_read  = !cap_write;
          rv_nx     = cap_write;
          cnt_nx    = '0;
          state_nx  = cap_write ? IDLE : WAIT;
        end
      WAIT:
        if (hit) begin
          rv_nx    = 1'b1;
          rd_nx    = ext;
          state_nx = IDLE;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          rv_nx    = 1'b1;
          re_nx    = 1'b1;
          cnt_nx   = cnt_inc;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
        end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_mem_initiator.sv
// tb_load_store_mem_initiator: scoreboard bench for the load/store memory initiator
module tb_load_store_mem_initiator;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_address = '0, req_wdata = '0;
  logic resp_valid, resp_error, busy, mem_read, mem_write, req_ready;
  logic [31:0] resp_rdata, mem_address, mem_wdata;
  logic [3:0] mem_byte_en;
  logic [31:0] mem_rdata = '0, mem_address_in = '0;
  logic mem_valid = 1'b0, mem_ready = 1'b1;
  load_store_mem_initiator #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_en(mem_byte_en), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_address_in(mem_address_in), .mem_valid(mem_valid),
    .mem_ready(mem_ready)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  typedef struct {logic err; logic [31:0] rd; int at;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0, n_rd = 0, n_wr = 0, n_resp = 0, s_cyc = 0, t0 = 0, r0 = 0;
  logic [3:0] s_be = '0;
  logic [31:0] s_addr = '0, s_wd = '0, echo_addr = '0;
  logic spam = 1'b0, mem_off = 1'b0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic step();
    logic rd_seen;
    logic [31:0] rd_addr;
    exp_t e;
    @(negedge clock);
    rd_seen = mem_read;
    rd_addr = mem_address;
    if (mem_read) n_rd++;
    if (mem_write) n_wr++;
    if (mem_read || mem_write) begin
      s_cyc  = cyc;
      s_be   = mem_byte_en;
      s_addr = mem_address;
      s_wd   = mem_wdata;
    end
    if (resp_valid) begin
      n_resp++;
      if (sb.size() == 0) check("spurious_resp", 32'(resp_valid), 32'd0);
      else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rd);
        check("resp_error", 32'(resp_error), 32'(e.err));
        check("resp_cycle", cyc, e.at);
      end
    end
    @(posedge clock);
    #1;
    mem_valid = spam || (rd_seen && !mem_off);
    mem_address_in = spam ? echo_addr : rd_addr;
  endtask
  task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                       input logic [31:0] d, input bit push, input bit err,
                       input logic [31:0] rd, input int lat);
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_address = a;
    req_wdata = d;
    n_rd = 0;
    n_wr = 0;
    t0 = cyc;
    if (push) begin
      e.err = err;
      e.rd = rd;
      e.at = cyc + lat;
      sb.push_back(e);
    end
    step();
    req_valid = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      check("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask
  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_byte_en", 32'(mem_byte_en), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    step();
    mem_rdata = 32'hDEADBEEF;
    issue(0, 2'b10, 0, 32'h100, 0, 1, 0, 32'hDEADBEEF, 3);
    wait_done();
    check("wl_reads", n_rd, 1);
    check("wl_byte_en", 32'(s_be), 32'hF);
    check("wl_addr", s_addr, 32'h100);
    check("wl_strobe_cyc", s_cyc, t0 + 1);
    mem_rdata = 32'h80FF0000;
    issue(0, 2'b00, 0, 32'h103, 0, 1, 0, 32'hFFFFFF80, 3);
    wait_done();
    check("lb_byte_en", 32'(s_be), 32'h8);
    check("lb_addr", s_addr, 32'h100);
    issue(0, 2'b00, 1, 32'h103, 0, 1, 0, 32'h00000080, 3);
    wait_done();
    mem_rdata = 32'h1234F00D;
    issue(0, 2'b01, 0, 32'h100, 0, 1, 0, 32'hFFFFF00D, 3);
    wait_done();
    check("lh_byte_en", 32'(s_be), 32'h3);
    issue(0, 2'b01, 1, 32'h102, 0, 1, 0, 32'h00001234, 3);
    wait_done();
    issue(0, 2'b00, 0, 32'h101, 0, 1, 0, 32'hFFFFFFF0, 3);
    wait_done();
    check("lb1_byte_en", 32'(s_be), 32'h2);
    mem_ready = 1'b0;
    issue(1, 2'b01, 0, 32'h102, 32'h00001234, 1, 0, 32'd0, 5);
    repeat (3) step();
    check("st_stall_writes", n_wr, 0);
    mem_ready = 1'b1;
    wait_done();
    check("st_writes", n_wr, 1);
    check("st_reads", n_rd, 0);
    check("st_strobe_cyc", s_cyc, t0 + 4);
    check("st_byte_en", 32'(s_be), 32'hC);
    check("st_wdata", s_wd, 32'h12341234);
    check("st_addr", s_addr, 32'h100);
    issue(1, 2'b00, 0, 32'h101, 32'h000000AB, 1, 0, 32'd0, 2);
    wait_done();
    check("sb_byte_en", 32'(s_be), 32'h2);
    check("sb_wdata", s_wd, 32'hABABABAB);
    issue(0, 2'b10, 0, 32'h101, 0, 1, 1, 32'd0, 1);
    wait_done();
    check("mis_word_strobes", n_rd + n_wr, 0);
    issue(0, 2'b11, 0, 32'h0, 0, 1, 1, 32'd0, 1);
    wait_done();
    check("illegal_strobes", n_rd + n_wr, 0);
    issue(1, 2'b01, 0, 32'h103, 32'hFFFF, 1, 1, 32'd0, 1);
    wait_done();
    check("mis_half_strobes", n_rd + n_wr, 0);
    issue(1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 1, 0, 32'd0, 2);
    step();
    mem_rdata = 32'h11223344;
    issue(0, 2'b10, 0, 32'h44, 0, 1, 0, 32'h11223344, 3);
    wait_done();
    check("b2b_addr", s_addr, 32'h44);
    spam = 1'b1;
    echo_addr = 32'h200;
    mem_rdata = 32'hCAFEF00D;
    issue(0, 2'b10, 0, 32'h100, 0, 1, 1, 32'd0, 10);
    wait_done();
    spam = 1'b0;
    check("to_reads", n_rd, 1);
    step();
    mem_off = 1'b1;
    issue(0, 2'b10, 0, 32'h100, 0, 0, 0, 32'd0, 0);
    step();
    step();
    check("rw_busy_wait", 32'(busy), 32'd1);
    r0 = n_resp;
    reset = 1'b0;
    #1;
    check("rw_req_ready", 32'(req_ready), 32'd1);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_mem_read", 32'(mem_read), 32'd0);
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_mem_address", mem_address, 32'd0);
    step();
    reset = 1'b1;
    mem_off = 1'b0;
    mem_valid = 1'b1;
    mem_address_in = 32'h100;
    mem_rdata = 32'h55AA55AA;
    step();
    repeat (3) step();
    check("rw_no_resp", n_resp, r0);
    check("rw_idle", 32'(req_ready), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
